// File: rtl/fp32_add_packer.sv
// fp32_add_packer: back end of the fp32 adder. Normalises the raw magnitude
// sum one left shift per clock, rounds to nearest-even and packs a binary32
// word. Specials (NaN/inf) bypass the datapath.
// Optional build macro: FP_PACK_FTZ_EN (flush denormal results to signed zero).
module fp32_add_packer #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int MANT_W = 48
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    legal,
   input  logic                    NaN_res,
   input  logic                    inf_res,
   input  logic                    res_sig,
   input  logic [EXP_W-1:0]        exp_max,
   input  logic [MANT_W:0]         sum_mant,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   result
);

   typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

   state_t        r_state;
   logic          r_in_ready;
   logic          r_out_valid;
   logic [31:0]   r_result;
   logic [47:0]   r_mant;
   logic [9:0]    r_exp;
   logic          r_sig;

   logic [47:0]   w_mant_in;
   logic [9:0]    w_exp_base;
   logic [31:0]   w_special_res;
   logic          w_g;
   logic          w_r;
   logic          w_s;
   logic [23:0]   w_k;
   logic [24:0]   w_ksum;
   logic [23:0]   w_kfin;
   logic [9:0]    w_efin;
   logic [7:0]    w_expf;
   logic [31:0]   w_round_res;
   logic          w_shift;

   // Carry pre-shift keeps the dropped bit as sticky in bit 0
   assign w_mant_in     = sum_mant[48] ? {sum_mant[48:2], sum_mant[1] | sum_mant[0]}
                                       : sum_mant[47:0];
   assign w_exp_base    = (exp_max == '0) ? 10'd1 : {2'b00, exp_max};
   assign w_special_res = NaN_res ? 32'h7FC0_0000 :
                          inf_res ? {res_sig, 8'hFF, 23'h0} : {res_sig, 31'h0};
   assign w_shift       = !r_mant[47] && (r_mant != '0) && (r_exp > 10'd1);

   // Round-to-nearest-even on the normalised mantissa and pack the word
   always_comb begin
      w_g    = r_mant[23];
      w_r    = r_mant[22];
      w_s    = |r_mant[21:0];
      w_k    = r_mant[47:24];
      w_ksum = {1'b0, w_k} + {24'd0, (w_g & (w_r | w_s | w_k[0]))};
      if (w_ksum[24]) begin
         w_kfin = w_ksum[24:1];
         w_efin = r_exp + 10'd1;
      end else begin
         w_kfin = w_ksum[23:0];
         w_efin = r_exp;
      end
      w_expf = w_kfin[23] ? w_efin[7:0] : 8'h00;
      if (w_efin >= 10'd255)
         w_round_res = {r_sig, 8'hFF, 23'h0};
      else if (r_mant == '0)
         w_round_res = {r_sig, 31'h0};
      else
         w_round_res = {r_sig, w_expf, w_kfin[22:0]};
`ifdef FP_PACK_FTZ_EN
      if ((w_round_res[30:23] == 8'h00) && (w_round_res[22:0] != 23'h0))
         w_round_res = {r_sig, 31'h0};
`else
`endif
   end

   // Control FSM with registered handshake outputs and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_mant      <= '0;
         r_exp       <= '0;
         r_sig       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_in_ready) begin
                  r_in_ready <= 1'b1;
               end else if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_sig      <= res_sig;
                  r_mant     <= w_mant_in;
                  r_exp      <= w_exp_base + {9'd0, sum_mant[48]};
                  if (!legal) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_NORM;
                  end
               end
            end
            S_NORM: begin
               if (w_shift) begin
                  r_mant <= {r_mant[46:0], 1'b0};
                  r_exp  <= r_exp - 10'd1;
               end else begin
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_result    <= w_round_res;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               // Specials arrive here without out_valid; raise it one cycle later
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;

endmodule

// File: tb/tb_fp32_add_packer.sv
// Testbench for fp32_add_packer: directed cases pinned to hand values plus
// randomized bundles checked against an arithmetic reference model.
module tb_fp32_add_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        legal = 1'b0;
   logic        NaN_res = 1'b0;
   logic        inf_res = 1'b0;
   logic        res_sig = 1'b0;
   logic [7:0]  exp_max = '0;
   logic [48:0] sum_mant = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit done = 1'b0;

   logic [31:0] q_res[$];
   int          q_lat[$];
   int          q_acc[$];

   fp32_add_packer #(.EXP_W(8), .FRAC_W(23), .MANT_W(48)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .legal(legal), .NaN_res(NaN_res), .inf_res(inf_res), .res_sig(res_sig),
      .exp_max(exp_max), .sum_mant(sum_mant), .out_valid(out_valid),
      .out_ready(out_ready), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: value semantics of normalise + RNE, latency 2 + shift count
   function automatic void model(input bit lg, input bit nan, input bit inf, input bit sg,
                                 input logic [7:0] ex, input logic [48:0] sm,
                                 output logic [31:0] res, output int lat);
      int           e;
      int           n;
      logic [48:0]  m;
      logic [24:0]  k;
      logic [23:0]  rem;
      if (!lg) begin
         res = nan ? 32'h7FC0_0000 : (inf ? {sg, 8'hFF, 23'h0} : {sg, 31'h0});
         lat = 1;
         return;
      end
      e = (ex == 0) ? 1 : int'(ex);
      m = sm;
      if (m[48]) begin
         m = (m >> 1) | (m & 49'd1);
         e = e + 1;
      end
      n = 0;
      if (m != 0) begin
         while (!m[47] && e > 1) begin
            m = m << 1;
            e = e - 1;
            n = n + 1;
         end
      end
      k   = {1'b0, m[47:24]};
      rem = m[23:0];
      if (rem > 24'h800000 || (rem == 24'h800000 && k[0])) k = k + 25'd1;
      if (k[24]) begin
         k = k >> 1;
         e = e + 1;
      end
      if (e >= 255)      res = {sg, 8'hFF, 23'h0};
      else if (m == 0)   res = {sg, 31'h0};
      else               res = {sg, (k[23] ? 8'(e) : 8'h00), k[22:0]};
`ifdef FP_PACK_FTZ_EN
      if (res[30:23] == 8'h00 && res[22:0] != 23'h0) res = {sg, 31'h0};
`endif
      lat = 2 + n;
   endfunction

   task automatic send(input bit lg, input bit nan, input bit inf, input bit sg,
                       input logic [7:0] ex, input logic [48:0] sm, input int stall);
      int          t;
      logic [31:0] er;
      int          el;
      t = 0;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", {31'h0, in_ready}, 32'h1);
         return;
      end
      legal = lg; NaN_res = nan; inf_res = inf; res_sig = sg;
      exp_max = ex; sum_mant = sm; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      model(lg, nan, inf, sg, ex, sm, er, el);
      q_res.push_back(er);
      q_lat.push_back(el);
      q_acc.push_back(cyc);
      t = 0;
      while (!out_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         chk("out_valid_timeout", {31'h0, out_valid}, 32'h1);
         q_res.delete(); q_lat.delete(); q_acc.delete();
         return;
      end
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic directed(input string name, input bit lg, input bit nan, input bit inf,
                           input bit sg, input logic [7:0] ex, input logic [48:0] sm,
                           input logic [31:0] lit_res, input int lit_lat, input int stall);
      logic [31:0] r;
      int          l;
      model(lg, nan, inf, sg, ex, sm, r, l);
      chk({"model_res_", name}, r, lit_res);
      chk({"model_lat_", name}, 32'(l), 32'(lit_lat));
      send(lg, nan, inf, sg, ex, sm, stall);
   endtask

   initial begin
      fork
         // Output monitor: result, latency, stability and in_ready while valid
         begin
            bit          pv;
            logic [31:0] cur;
            int          el;
            int          acc;
            pv  = 1'b0;
            cur = '0;
            while (!done) begin
               @(negedge clk);
               if (out_valid) begin
                  if (!pv) begin
                     if (q_res.size() == 0) begin
                        chk("unexpected_out_valid", 32'h1, 32'h0);
                     end else begin
                        cur = q_res.pop_front();
                        el  = q_lat.pop_front();
                        acc = q_acc.pop_front();
                        chk("result", result, cur);
                        chk("latency", 32'(cyc - acc), 32'(el));
                     end
                  end else begin
                     chk("result_stable", result, cur);
                  end
                  chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
               end
               pv = out_valid;
            end
         end
         // Stimulus
         begin
            logic [63:0] r64;
            logic [48:0] s;
            logic [7:0]  ex;
            bit          lg;
            int          t;
            #2;
            chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
            chk("reset_result", result, 32'h0);
            chk("reset_in_ready", {31'h0, in_ready}, 32'h0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;

            directed("one_plus_one", 1, 0, 0, 0, 8'd127, 49'h1_0000_0000_0000, 32'h4000_0000, 2, 5);
            directed("one_minus_075", 1, 0, 0, 0, 8'd127, 49'h0_2000_0000_0000, 32'h3E80_0000, 4, 0);
            directed("rne_odd_tie", 1, 0, 0, 0, 8'd127, {1'b0, 24'h800001, 24'h800000}, 32'h3F80_0002, 2, 1);
            directed("rne_even_tie", 1, 0, 0, 0, 8'd127, {1'b0, 24'h800000, 24'h800000}, 32'h3F80_0000, 2, 0);
            directed("rne_sticky", 1, 0, 0, 0, 8'd127, {1'b0, 24'h800000, 24'h800001}, 32'h3F80_0001, 2, 2);
            directed("overflow", 1, 0, 0, 0, 8'd254, 49'h1_0000_0000_0000, 32'h7F80_0000, 2, 0);
            directed("nan_prio", 0, 1, 1, 1, 8'd3, 49'h0, 32'h7FC0_0000, 1, 0);
            directed("neg_inf", 0, 0, 1, 1, 8'd3, 49'h0, 32'hFF80_0000, 1, 3);
`ifdef FP_PACK_FTZ_EN
            directed("denormal", 1, 0, 0, 0, 8'd0, 49'h0_2000_0000_0000, 32'h0000_0000, 2, 0);
`else
            directed("denormal", 1, 0, 0, 0, 8'd0, 49'h0_2000_0000_0000, 32'h0020_0000, 2, 0);
`endif
            directed("denorm_to_norm", 1, 0, 0, 0, 8'd0, {1'b0, 24'h7FFFFF, 24'h800000}, 32'h0080_0000, 2, 0);
            directed("neg_zero", 1, 0, 0, 1, 8'd127, 49'h0, 32'h8000_0000, 2, 0);

            for (int i = 0; i < 300; i++) begin
               r64 = {$urandom, $urandom};
               s   = r64[48:0] >> $urandom_range(0, 49);
               if ($urandom_range(0, 3) == 0) s[23:0] = 24'h800000;
               ex  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 254));
               lg  = ($urandom_range(0, 9) != 0);
               send(lg, 1'($urandom), 1'($urandom), 1'($urandom), ex, s, $urandom_range(0, 3));
            end

            // Abort during normalisation: outputs clear asynchronously
            t = 0;
            while (!in_ready && t < 300) begin
               @(negedge clk);
               t++;
            end
            legal = 1'b1; NaN_res = 1'b0; inf_res = 1'b0; res_sig = 1'b0;
            exp_max = 8'd127; sum_mant = 49'h20; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
            chk("abort_result", result, 32'h0);
            chk("abort_in_ready", {31'h0, in_ready}, 32'h0);
            q_res.delete(); q_lat.delete(); q_acc.delete();
            @(negedge clk);
            rst_n = 1'b1;
            directed("after_abort", 1, 0, 0, 0, 8'd127, 49'h1_0000_0000_0000, 32'h4000_0000, 2, 0);
            repeat (3) @(negedge clk);
            done = 1'b1;
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
